// File: rtl/bcd_serial_addsub_if.sv
// Operand/result bundle for the serial BCD adder/subtractor: start request, operands, status and segment drive.
interface bcd_serial_addsub_if #(parameter int DIGITS = 4);
    logic                      start;
    logic                      sub;
    logic [4*DIGITS-1:0]       a;
    logic [4*DIGITS-1:0]       b;
    logic                      busy;
    logic                      done;
    logic [4*DIGITS-1:0]       sum;
    logic                      carry;
    logic                      neg;
    logic                      invalid;
    logic [7*(DIGITS+1)-1:0]   hex;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry, neg, invalid, hex
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry, neg, invalid, hex
    );
endinterface

// File: rtl/bcd_serial_addsub.sv
// N-digit BCD add/sub, one digit per clock LSD first; done after DIGITS cycles (2*DIGITS if negative, 1 if invalid).
// No backpressure: start is taken only when idle, results hold until the next accepted start.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    bcd_serial_addsub_if.slave io
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          c, c_nxt;
    logic          sub_q, sub_nxt;
    logic          pend, pend_nxt;
    logic [W-1:0]  a_q, a_nxt;
    logic [W-1:0]  b_q, b_nxt;
    logic [W-1:0]  sum_q, sum_nxt;
    logic          carry_q, carry_nxt;
    logic          neg_q, neg_nxt;
    logic          inv_q, inv_nxt;

    logic          in_bad;
    logic [3:0]    da, db, ds, y, dig;
    logic [4:0]    t, tm;
    logic          cout, last;
    logic [7*(DIGITS+1)-1:0] hex_c;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        // packed as {g,f,e,d,c,b,a}, active low
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (io.a[4*i +: 4] > 4'd9 || io.b[4*i +: 4] > 4'd9)
                in_bad = 1'b1;
        end
    end

    // Shared digit adder: RUN adds a_i + (b_i or 9-b_i) + c, FIX complements the stored digit.
    always_comb begin
        da   = a_q[4*idx +: 4];
        db   = b_q[4*idx +: 4];
        ds   = sum_q[4*idx +: 4];
        y    = sub_q ? (4'd9 - db) : db;
        if (state == FIX)
            t = 5'(4'd9 - ds) + 5'(c);
        else
            t = 5'(da) + 5'(y) + 5'(c);
        tm   = t - 5'd10;
        cout = (t > 5'd9);
        dig  = cout ? tm[3:0] : t[3:0];
        last = (idx == IW'(DIGITS - 1));
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        c_nxt     = c;
        sub_nxt   = sub_q;
        pend_nxt  = pend;
        a_nxt     = a_q;
        b_nxt     = b_q;
        sum_nxt   = sum_q;
        carry_nxt = carry_q;
        neg_nxt   = neg_q;
        inv_nxt   = inv_q;
        case (state)
            IDLE: begin
                if (pend) begin
                    // rejected operands still report one cycle after acceptance
                    pend_nxt  = 1'b0;
                    inv_nxt   = 1'b1;
                    state_nxt = DONE;
                end else if (io.start) begin
                    a_nxt     = io.a;
                    b_nxt     = io.b;
                    sub_nxt   = io.sub;
                    sum_nxt   = '0;
                    carry_nxt = 1'b0;
                    neg_nxt   = 1'b0;
                    inv_nxt   = 1'b0;
                    idx_nxt   = '0;
                    c_nxt     = io.sub;
                    if (in_bad)
                        pend_nxt = 1'b1;
                    else
                        state_nxt = RUN;
                end
            end
            RUN: begin
                sum_nxt[4*idx +: 4] = dig;
                c_nxt   = cout;
                idx_nxt = idx + IW'(1);
                if (last) begin
                    if (!sub_q) begin
                        carry_nxt = cout;
                        state_nxt = DONE;
                    end else if (cout) begin
                        state_nxt = DONE;
                    end else begin
                        neg_nxt   = 1'b1;
                        idx_nxt   = '0;
                        c_nxt     = 1'b1;
                        state_nxt = FIX;
                    end
                end
            end
            FIX: begin
                sum_nxt[4*idx +: 4] = dig;
                c_nxt   = cout;
                idx_nxt = idx + IW'(1);
                if (last)
                    state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            c       <= 1'b0;
            sub_q   <= 1'b0;
            pend    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            c       <= c_nxt;
            sub_q   <= sub_nxt;
            pend    <= pend_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            sum_q   <= sum_nxt;
            carry_q <= carry_nxt;
            neg_q   <= neg_nxt;
            inv_q   <= inv_nxt;
        end
    end

    always_comb begin
        hex_c = '1;
        for (int i = 0; i < DIGITS; i++)
            hex_c[7*i +: 7] = seg7(sum_q[4*i +: 4]);
        if (carry_q)
            hex_c[7*DIGITS +: 7] = 7'b1111001;
        else if (neg_q)
            hex_c[7*DIGITS +: 7] = 7'b0111111;
        else
            hex_c[7*DIGITS +: 7] = 7'b1111111;
    end

    assign io.busy    = (state == RUN) || (state == FIX);
    assign io.done    = (state == DONE);
    assign io.sum     = sum_q;
    assign io.carry   = carry_q;
    assign io.neg     = neg_q;
    assign io.invalid = inv_q;
    assign io.hex     = hex_c;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed vectors for the 4-digit serial BCD adder/subtractor plus a reset-abort sequence.
module tb_bcd_serial_addsub;
    localparam int D  = 4;
    localparam int NV = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_serial_addsub_if #(.DIGITS(D)) io ();

    bcd_serial_addsub #(.DIGITS(D)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        carry;
        logic        neg;
        logic        inv;
        int          lat;
        int          bcnt;
    } vec_t;

    vec_t       vt [NV];
    logic [6:0] seg_ag [10];   // segment strings written a..g left to right
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] place(input logic [6:0] s);
        logic [6:0] r;
        for (int j = 0; j < 7; j++)
            r[j] = s[6-j];
        return r;
    endfunction

    function automatic logic [34:0] exp_hex(input logic [15:0] s, input logic cy, input logic ng);
        logic [34:0] h;
        for (int i = 0; i < 4; i++)
            h[7*i +: 7] = place(seg_ag[s[4*i +: 4]]);
        if (cy)
            h[28 +: 7] = place(7'b1001111);
        else if (ng)
            h[28 +: 7] = place(7'b1111110);
        else
            h[28 +: 7] = 7'b1111111;
        return h;
    endfunction

    task automatic do_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int bcnt, output logic to);
        @(negedge clk);
        io.start = 1'b1;
        io.sub   = s;
        io.a     = a;
        io.b     = b;
        @(negedge clk);
        io.start = 1'b0;
        lat  = 0;
        bcnt = io.busy ? 1 : 0;
        to   = 1'b0;
        while (!io.done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (io.busy) bcnt++;
        end
        if (!io.done) to = 1'b1;
    endtask

    initial begin
        int   lat, bcnt;
        logic to;
        logic saw_done;

        seg_ag[0] = 7'b0000001; seg_ag[1] = 7'b1001111; seg_ag[2] = 7'b0010010;
        seg_ag[3] = 7'b0000110; seg_ag[4] = 7'b1001100; seg_ag[5] = 7'b0100100;
        seg_ag[6] = 7'b0100000; seg_ag[7] = 7'b0001111; seg_ag[8] = 7'b0000000;
        seg_ag[9] = 7'b0000100;

        //          sub   a         b         sum       cy    ng    inv   lat bcnt
        vt[0]  = '{1'b0, 16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0, 4, 4};
        vt[1]  = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 4};
        vt[2]  = '{1'b1, 16'h0123, 16'h0456, 16'h0333, 1'b0, 1'b1, 1'b0, 8, 8};
        vt[3]  = '{1'b1, 16'h0500, 16'h0500, 16'h0000, 1'b0, 1'b0, 1'b0, 4, 4};
        vt[4]  = '{1'b0, 16'h5000, 16'h5000, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 4};
        vt[5]  = '{1'b1, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 4, 4};
        vt[6]  = '{1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 8, 8};
        vt[7]  = '{1'b0, 16'h00A0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 0};
        vt[8]  = '{1'b0, 16'h4567, 16'h5433, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 4};
        vt[9]  = '{1'b1, 16'h0010, 16'hF000, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 0};
        vt[10] = '{1'b1, 16'h0456, 16'h0123, 16'h0333, 1'b0, 1'b0, 1'b0, 4, 4};

        io.start = 1'b0;
        io.sub   = 1'b0;
        io.a     = '0;
        io.b     = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",  64'(io.busy),    64'(0));
        check("rst_done",  64'(io.done),    64'(0));
        check("rst_sum",   64'(io.sum),     64'(0));
        check("rst_carry", 64'(io.carry),   64'(0));
        check("rst_neg",   64'(io.neg),     64'(0));
        check("rst_inv",   64'(io.invalid), 64'(0));
        check("rst_hex",   64'(io.hex),     64'(exp_hex(16'h0000, 1'b0, 1'b0)));

        for (int i = 0; i < NV; i++) begin
            do_op(vt[i].sub, vt[i].a, vt[i].b, lat, bcnt, to);
            check($sformatf("v%0d_timeout", i), 64'(to),          64'(0));
            check($sformatf("v%0d_lat", i),     64'(lat),         64'(vt[i].lat));
            check($sformatf("v%0d_busy", i),    64'(bcnt),        64'(vt[i].bcnt));
            check($sformatf("v%0d_busy_at_done", i), 64'(io.busy), 64'(0));
            check($sformatf("v%0d_sum", i),     64'(io.sum),      64'(vt[i].sum));
            check($sformatf("v%0d_carry", i),   64'(io.carry),    64'(vt[i].carry));
            check($sformatf("v%0d_neg", i),     64'(io.neg),      64'(vt[i].neg));
            check($sformatf("v%0d_inv", i),     64'(io.invalid),  64'(vt[i].inv));
            check($sformatf("v%0d_hex", i),     64'(io.hex),
                  64'(exp_hex(vt[i].sum, vt[i].carry, vt[i].neg)));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 64'(io.done), 64'(0));
            check($sformatf("v%0d_hold_sum", i),   64'(io.sum),  64'(vt[i].sum));
        end

        // start again mid-run (ignored), then reset aborts with no done
        @(negedge clk);
        io.start = 1'b1;
        io.sub   = 1'b0;
        io.a     = 16'h1234;
        io.b     = 16'h4321;
        @(negedge clk);
        io.start = 1'b0;
        saw_done = io.done;
        @(negedge clk);
        saw_done |= io.done;
        io.start = 1'b1;
        @(negedge clk);
        saw_done |= io.done;
        io.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        saw_done |= io.done;
        check("abort_no_done", 64'(saw_done),   64'(0));
        check("abort_busy",    64'(io.busy),    64'(0));
        check("abort_sum",     64'(io.sum),     64'(0));
        check("abort_carry",   64'(io.carry),   64'(0));
        check("abort_neg",     64'(io.neg),     64'(0));
        check("abort_inv",     64'(io.invalid), 64'(0));
        check("abort_hex",     64'(io.hex),     64'(exp_hex(16'h0000, 1'b0, 1'b0)));
        rst = 1'b0;

        do_op(1'b0, 16'h1234, 16'h4321, lat, bcnt, to);
        check("fresh_timeout", 64'(to),      64'(0));
        check("fresh_lat",     64'(lat),     64'(4));
        check("fresh_sum",     64'(io.sum),  64'(16'h5555));
        check("fresh_hex",     64'(io.hex),  64'(exp_hex(16'h5555, 1'b0, 1'b0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_serial_addsub.md
# bcd_serial_addsub

Parametrised N-digit BCD adder/subtractor that processes one decimal digit per clock, least-significant first, and drives active-low seven-segment patterns for the result. Successor to the fixed two-digit combinational BCD adder used in the display labs. It adds a start/done handshake, subtract mode with a signed-magnitude result, and input-digit validation. It sits between switch/register operands and the HEX display bank.

## Interface
- DIGITS, default 4 — BCD digits per operand, legal range 1..8; result width 4*DIGITS.
- Clock  in  1  — rising-edge clock.
- Reset  in  1  — asynchronous, active-high; returns block to IDLE.
- start  in  1  — request; sampled only in IDLE.
- sub  in  1  — 0 = a+b, 1 = a−b; latched with start.
- a  in  4*DIGITS  — operand A, digit i = a[4i+3:4i].
- b  in  4*DIGITS  — operand B, same packing.
- busy  out  1  — high in RUN and FIX.
- done  out  1  — one-cycle pulse, result valid.
- sum  out  4*DIGITS  — result magnitude, BCD.
- carry  out  1  — add overflow (a+b ≥ 10^DIGITS).
- neg  out  1  — subtract result negative (a<b).
- invalid  out  1  — a latched operand digit was >9.
- hex  out  7*(DIGITS+1)  — active-low segments; digit i at hex[7i+6:7i], bit 7i = seg a … 7i+6 = seg g; digit DIGITS is the sign/overflow digit.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: on start=1, latch a, b, sub, clear sum/carry/neg/invalid, idx=0.
  - If any latched digit >9 → DONE, invalid=1, sum=0.
  - Else → RUN, with c=0 for add, c=1 for sub.
- RUN, one digit per cycle at idx:
  - Operand y = b_i for add, 9−b_i for sub.
  - t = a_i + y + c, 5-bit.
  - If t>9: sum_i = t−10, c=1; else sum_i = t, c=0.
  - idx increments each cycle.
  - After digit DIGITS−1:
    - add: carry=c → DONE.
    - sub with c=1 (no borrow): neg=0 → DONE.
    - sub with c=0: neg=1, idx=0, c=1 → FIX.
- FIX: per cycle, t = (9−sum_i) + c, same >9 correction, written back to sum_i. This is the ten's complement, giving magnitude b−a. After digit DIGITS−1 → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- start is ignored outside IDLE, including the DONE cycle.
- sum, carry, neg and invalid hold until the next accepted start.
- hex is decoded combinationally from registers at all times; mid-operation patterns are don't-care.
  - Digits 0..DIGITS−1 show sum_i as 0–9.
  - Sign digit shows "1" if carry, "−" (seg g only) if neg, else blank (all 1s).
- Reset mid-operation aborts. No done pulse is produced; all state clears.

## Timing
- Reset values:
  - busy=0, done=0, sum=0, carry=0, neg=0, invalid=0, state IDLE.
  - hex: digit patterns "0" (0000001), sign digit 1111111.
- Edge E0 accepts start; busy=1 after E0.
- RUN occupies edges E1..E_DIGITS.
- done latency from E0:
  - add, or non-negative sub: high after E_DIGITS, i.e. DIGITS cycles.
  - negative sub: DIGITS more cycles, done after E_(2·DIGITS).
  - invalid: high after E1, 1 cycle; busy never asserts.
- busy falls in the same cycle done rises.
- Earliest next accepted start is the edge after the done cycle.
- DIGITS=1: a single RUN cycle and a single FIX cycle.

## Test plan
- DIGITS=4, add 0999+0001 → done 4 cycles after accept; sum=1000, carry=0, sign digit blank.
- Add 9999+0001 → sum=0000, carry=1, sign digit 1001111; busy high for exactly 4 cycles.
- Sub 0123−0456 → done after 8 cycles; sum=0333, neg=1, sign digit 1111110.
- Sub 0500−0500 → done after 4 cycles; sum=0000, neg=0. Then add 5000+5000 → sum=0000, carry=1, and neg has cleared to 0.
- a=00A0, add → done 1 cycle after accept, invalid=1, sum=0000, busy stays 0. Next valid start clears invalid.
- Start add 1234+4321, pulse start again at E2 (ignored), assert Reset at E3 → all outputs return to reset values, no done. A fresh start then gives sum=5555 after 4 cycles.
